// File: rtl/seq_divider_pkg.sv
// package_settings: shared settings for the sequential divider.
//   SIZE_DATA   - default operand/result width
//   DIV_MAX_W   - widest operand the div_abs helper can handle
//   div_state_t - divider FSM state encoding
//   div_abs     - magnitude of a (possibly signed) value of a given width
package package_settings;

  localparam int SIZE_DATA = 8;
  localparam int DIV_MAX_W = 64;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE} div_state_t;

  // Operates on a zero-extended DIV_MAX_W container so any DATA_WIDTH up to
  // DIV_MAX_W can share one helper; the caller truncates the result back.
  function automatic logic [DIV_MAX_W-1:0] div_abs(input logic [DIV_MAX_W-1:0] value,
                                                   input int width,
                                                   input logic is_signed);
    logic [DIV_MAX_W-1:0] mask;
    mask = (width >= DIV_MAX_W) ? '1 : ((DIV_MAX_W'(1) << width) - DIV_MAX_W'(1));
    if (is_signed && value[6'(width - 1)]) begin
      return (~value + DIV_MAX_W'(1)) & mask;
    end
    return value & mask;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// divider_step: one combinational restoring-division iteration.
//   rem_in   - partial remainder (always < divisor)
//   bit_in   - next dividend bit shifted in
//   divisor  - divisor magnitude
//   rem_out  - next partial remainder
//   q_bit    - quotient bit produced by this iteration
module divider_step
  import package_settings::*;
#(
  parameter int WIDTH = SIZE_DATA
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // Because rem_in < divisor, the trial difference always lies inside the
  // signed range of WIDTH+1 bits, so bit WIDTH is a reliable sign.
  always_comb begin
    trial = {rem_in, bit_in} - {1'b0, divisor};
    if (trial[WIDTH]) begin
      rem_out = {rem_in[WIDTH-2:0], bit_in};
      q_bit   = 1'b0;
    end else begin
      rem_out = trial[WIDTH-1:0];
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider with valid/ready
// handshakes, signed or unsigned operation and divide-by-zero/overflow flags.
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_ready     - operand handshake (in_ready high only when idle)
//   dividend, divisor     - operands
//   out_valid/out_ready   - result handshake (result held until accepted)
//   quotient, remainder   - results, quotient truncated toward zero
//   div_by_zero, overflow - status flags, valid with out_valid
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DIV_IDLE | waiting for operands, in_ready high
// DIV_CALC | one restoring iteration per cycle, DATA_WIDTH cycles
// DIV_FIX  | apply result signs, load output registers
// DIV_DONE | raise out_valid one cycle after entry, hold until accepted
module seq_divider
  import package_settings::*;
#(
  parameter int DATA_WIDTH  = SIZE_DATA,
  parameter int SIGNED_MODE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic IS_SIGNED = (SIGNED_MODE != 0);

  div_state_t state, state_next;

  logic [DATA_WIDTH-1:0] rem_r, dvd_r, dsr_r;
  logic [DATA_WIDTH-1:0] step_rem, dvd_mag, dsr_mag;
  logic                  step_q;
  logic [CNT_W-1:0]      cnt;
  logic                  qneg, rneg;
  logic                  accept, is_zero, is_ovf;

  assign accept  = in_valid && in_ready;
  assign is_zero = (divisor == '0);
  assign is_ovf  = IS_SIGNED && (dividend == MIN_VAL) && (divisor == '1);
  assign dvd_mag = DATA_WIDTH'(div_abs(DIV_MAX_W'(dividend), DATA_WIDTH, IS_SIGNED));
  assign dsr_mag = DATA_WIDTH'(div_abs(DIV_MAX_W'(divisor), DATA_WIDTH, IS_SIGNED));

  // dvd_r doubles as the quotient accumulator: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  divider_step #(.WIDTH(DATA_WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[DATA_WIDTH-1]),
    .divisor (dsr_r),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (accept) state_next = (is_zero || is_ovf) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt == CNT_W'(DATA_WIDTH - 1)) state_next = DIV_FIX;
      DIV_FIX:  state_next = DIV_DONE;
      DIV_DONE: if (out_valid && out_ready) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      rem_r       <= '0;
      dvd_r       <= '0;
      dsr_r       <= '0;
      cnt         <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
    end else begin
      in_ready <= (state_next == DIV_IDLE);
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            div_by_zero <= is_zero;
            overflow    <= is_ovf;
            if (is_zero) begin
              quotient  <= '1;
              remainder <= dividend;
            end else if (is_ovf) begin
              quotient  <= MIN_VAL;
              remainder <= '0;
            end else begin
              dvd_r <= dvd_mag;
              dsr_r <= dsr_mag;
              rem_r <= '0;
              cnt   <= '0;
              qneg  <= IS_SIGNED && (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
              rneg  <= IS_SIGNED && dividend[DATA_WIDTH-1];
            end
          end
        end
        DIV_CALC: begin
          rem_r <= step_rem;
          dvd_r <= {dvd_r[DATA_WIDTH-2:0], step_q};
          cnt   <= cnt + CNT_W'(1);
        end
        DIV_FIX: begin
          quotient  <= qneg ? -dvd_r : dvd_r;
          remainder <= rneg ? -rem_r : rem_r;
        end
        DIV_DONE: begin
          // out_valid trails DONE entry by one cycle so results are settled
          // in their registers before they are advertised.
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dividend = '0, divisor = '0;
  logic       out_ready = 1'b0;
  logic       iv_s = 1'b0, iv_u = 1'b0;
  logic       ir_s, ir_u, ov_s, ov_u, dz_s, dz_u, of_s, of_u;
  logic [7:0] q_s, q_u, r_s, r_u;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seq_divider #(.DATA_WIDTH(8), .SIGNED_MODE(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(iv_s), .in_ready(ir_s),
    .dividend(dividend), .divisor(divisor), .out_valid(ov_s), .out_ready(out_ready),
    .quotient(q_s), .remainder(r_s), .div_by_zero(dz_s), .overflow(of_s)
  );

  seq_divider #(.DATA_WIDTH(8), .SIGNED_MODE(0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(iv_u), .in_ready(ir_u),
    .dividend(dividend), .divisor(divisor), .out_valid(ov_u), .out_ready(out_ready),
    .quotient(q_u), .remainder(r_u), .div_by_zero(dz_u), .overflow(of_u)
  );

  // index 0 = unsigned instance, index 1 = signed instance
  logic [1:0] iv_v, ir_v, ov_v, dz_v, of_v;
  logic [7:0] q_a [2];
  logic [7:0] r_a [2];
  always_comb begin
    iv_v = {iv_s, iv_u};
    ir_v = {ir_s, ir_u};
    ov_v = {ov_s, ov_u};
    dz_v = {dz_s, dz_u};
    of_v = {of_s, of_u};
    q_a[0] = q_u; q_a[1] = q_s;
    r_a[0] = r_u; r_a[1] = r_s;
  end

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         lat;
  } res_t;

  // Reference: plain integer division (truncates toward zero, remainder
  // takes the dividend's sign), plus the two special cases.
  function automatic res_t model(input bit sgn, input logic [7:0] a, input logic [7:0] b);
    res_t res;
    int sa, sb;
    res.dz = 1'b0; res.ov = 1'b0;
    if (b == 8'h00) begin
      res.q = 8'hFF; res.r = a; res.dz = 1'b1; res.lat = 1;
    end else if (sgn && a == 8'h80 && b == 8'hFF) begin
      res.q = 8'h80; res.r = 8'h00; res.ov = 1'b1; res.lat = 1;
    end else begin
      if (sgn) begin
        sa = int'($signed(a)); sb = int'($signed(b));
      end else begin
        sa = int'(a); sb = int'(b);
      end
      res.q = 8'(sa / sb);
      res.r = 8'(sa % sb);
      res.lat = 10;
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit   busy [2] = '{1'b0, 1'b0};
  res_t expv [2];
  int   rdy [2];

  // Scoreboard: records accepted operations and retired results.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      busy[0] = 1'b0; busy[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (busy[d] && ov_v[d] && out_ready) begin
          busy[d] = 1'b0;
        end else if (!busy[d] && iv_v[d] && ir_v[d]) begin
          expv[d] = model(d == 1, dividend, divisor);
          rdy[d]  = cyc + expv[d].lat;
          busy[d] = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, both instances.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) begin
          chk($sformatf("d%0d_out_valid", d), 32'(ov_v[d]), 32'(cyc >= rdy[d]));
          chk($sformatf("d%0d_in_ready_busy", d), 32'(ir_v[d]), 32'(0));
          if (ov_v[d]) begin
            chk($sformatf("d%0d_quotient", d), 32'(q_a[d]), 32'(expv[d].q));
            chk($sformatf("d%0d_remainder", d), 32'(r_a[d]), 32'(expv[d].r));
            chk($sformatf("d%0d_div_by_zero", d), 32'(dz_v[d]), 32'(expv[d].dz));
            chk($sformatf("d%0d_overflow", d), 32'(of_v[d]), 32'(expv[d].ov));
          end
        end else begin
          chk($sformatf("d%0d_idle_out_valid", d), 32'(ov_v[d]), 32'(0));
          chk($sformatf("d%0d_idle_in_ready", d), 32'(ir_v[d]), 32'(1));
        end
      end
    end
  end

  task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                       input int hold, input bit pulse,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dz, output logic ov, output int lat);
    int n;
    @(negedge clk);
    dividend = a; divisor = b;
    if (sel) iv_s = 1'b1; else iv_u = 1'b1;
    @(posedge clk); #1;
    iv_s = 1'b0; iv_u = 1'b0;
    n = 0;
    while (!ov_v[sel] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("result_within_bound", 32'(ov_v[sel]), 32'(1));
    lat = n;
    q = q_a[sel]; r = r_a[sel]; dz = dz_v[sel]; ov = of_v[sel];
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 2) begin
        dividend = 8'h11; divisor = 8'h01;
        if (sel) iv_s = 1'b1; else iv_u = 1'b1;
        chk("bp_in_ready", 32'(ir_v[sel]), 32'(0));
      end
      @(posedge clk); #1;
      iv_s = 1'b0; iv_u = 1'b0;
    end
    if (pulse) begin
      chk("bp_quotient_stable", 32'(q_a[sel]), 32'(q));
      chk("bp_valid_held", 32'(ov_v[sel]), 32'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] q, r, a, b;
    logic       dz, ov;
    int         lat;
    bit         sel;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_s", 32'(ir_s), 32'(1));
    chk("rst_out_valid_s", 32'(ov_s), 32'(0));
    chk("rst_quotient_s", 32'(q_s), 32'(0));
    chk("rst_flags_s", 32'({dz_s, of_s}), 32'(0));
    chk("rst_in_ready_u", 32'(ir_u), 32'(1));
    chk("rst_out_valid_u", 32'(ov_u), 32'(0));
    chk("rst_remainder_u", 32'(r_u), 32'(0));
    reset = 1'b0;

    do_op(1'b0, 8'd100, 8'd7, 0, 1'b0, q, r, dz, ov, lat);
    chk("u100_7_q", 32'(q), 32'd14);
    chk("u100_7_r", 32'(r), 32'd2);
    chk("u100_7_flags", 32'({dz, ov}), 32'(0));
    chk("u100_7_lat", 32'(lat), 32'd10);

    do_op(1'b1, 8'h9C, 8'd7, 0, 1'b0, q, r, dz, ov, lat);
    chk("sm100_7_q", 32'(q), 32'hF2);
    chk("sm100_7_r", 32'(r), 32'hFE);

    do_op(1'b1, 8'd100, 8'hF9, 1, 1'b0, q, r, dz, ov, lat);
    chk("s100_m7_q", 32'(q), 32'hF2);
    chk("s100_m7_r", 32'(r), 32'h02);

    do_op(1'b1, 8'h80, 8'hFF, 0, 1'b0, q, r, dz, ov, lat);
    chk("ovf_q", 32'(q), 32'h80);
    chk("ovf_r", 32'(r), 32'h00);
    chk("ovf_flag", 32'({dz, ov}), 32'b01);
    chk("ovf_lat", 32'(lat), 32'd1);

    do_op(1'b1, 8'd37, 8'd0, 0, 1'b0, q, r, dz, ov, lat);
    chk("dz_q", 32'(q), 32'hFF);
    chk("dz_r", 32'(r), 32'd37);
    chk("dz_flag", 32'({dz, ov}), 32'b10);
    chk("dz_lat", 32'(lat), 32'd1);
    do_op(1'b1, 8'd9, 8'd3, 0, 1'b0, q, r, dz, ov, lat);
    chk("after_dz_q", 32'(q), 32'd3);
    chk("after_dz_r", 32'(r), 32'd0);
    chk("after_dz_flags", 32'({dz, ov}), 32'(0));

    do_op(1'b1, 8'd50, 8'd6, 5, 1'b1, q, r, dz, ov, lat);
    chk("bp_q", 32'(q), 32'd8);
    chk("bp_r", 32'(r), 32'd2);

    // Reset in the middle of the iterations of 200 / 3.
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd3; iv_u = 1'b1;
    @(posedge clk); #1;
    iv_u = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(ir_u), 32'(1));
    chk("midrst_out_valid", 32'(ov_u), 32'(0));
    chk("midrst_quotient", 32'(q_u), 32'(0));
    chk("midrst_remainder", 32'(r_u), 32'(0));
    chk("midrst_flags", 32'({dz_u, of_u}), 32'(0));
    reset = 1'b0;
    do_op(1'b0, 8'd200, 8'd3, 0, 1'b0, q, r, dz, ov, lat);
    chk("u200_3_q", 32'(q), 32'd66);
    chk("u200_3_r", 32'(r), 32'd2);

    for (int i = 0; i < 80; i++) begin
      sel = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      case ($urandom_range(0, 9))
        0: b = 8'h00;
        1: begin a = 8'h80; b = 8'hFF; end
        2: b = 8'($urandom_range(1, 3));
        default: ;
      endcase
      do_op(sel, a, b, int'($urandom_range(0, 3)), 1'b0, q, r, dz, ov, lat);
      chk("rand_lat", 32'(lat), 32'(model(sel, a, b).lat));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
